// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures operands and control for EX, bypasses a same-cycle
// write-back, and inserts one bubble per load-use hazard while counting those bubbles.
module id_ex_stage #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 5,
    parameter int CTRL_W      = 8,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   id_valid,
    input  logic [ADDR_W-1:0]      id_readAddr1,
    input  logic [ADDR_W-1:0]      id_readAddr2,
    input  logic [DATA_W-1:0]      id_readData1,
    input  logic [DATA_W-1:0]      id_readData2,
    input  logic [ADDR_W-1:0]      id_writeAddr,
    input  logic [DATA_W-1:0]      id_imm,
    input  logic [CTRL_W-1:0]      id_ctrl,
    input  logic                   wb_regWrite,
    input  logic [ADDR_W-1:0]      wb_writeAddr,
    input  logic [DATA_W-1:0]      wb_writeData,
    input  logic                   flush,
    input  logic                   ex_hold,
    output logic                   ex_valid,
    output logic [ADDR_W-1:0]      ex_readAddr1,
    output logic [ADDR_W-1:0]      ex_readAddr2,
    output logic [DATA_W-1:0]      ex_operand1,
    output logic [DATA_W-1:0]      ex_operand2,
    output logic [ADDR_W-1:0]      ex_writeAddr,
    output logic [DATA_W-1:0]      ex_imm,
    output logic [CTRL_W-1:0]      ex_ctrl,
    output logic                   hazard_stall,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    logic              wbLive;
    logic [DATA_W-1:0] operand1;
    logic [DATA_W-1:0] operand2;

    // Register 0 is hard-wired zero, so it is never a bypass target and always reads 0.
    always_comb begin
        wbLive   = wb_regWrite && (wb_writeAddr != '0);
        operand1 = id_readData1;
        operand2 = id_readData2;
        if (wbLive && (wb_writeAddr == id_readAddr1)) operand1 = wb_writeData;
        if (wbLive && (wb_writeAddr == id_readAddr2)) operand2 = wb_writeData;
        if (id_readAddr1 == '0) operand1 = '0;
        if (id_readAddr2 == '0) operand2 = '0;
    end

    // A load sitting in EX whose destination is read by the instruction in ID.
    always_comb begin
        hazard_stall = id_valid && ex_valid && ex_ctrl[1] && (ex_writeAddr != '0) &&
                       ((ex_writeAddr == id_readAddr1) || (ex_writeAddr == id_readAddr2));
    end

    // Flush beats hold beats bubble beats capture; only a bubble advances the counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_valid     <= 1'b0;
            ex_readAddr1 <= '0;
            ex_readAddr2 <= '0;
            ex_operand1  <= '0;
            ex_operand2  <= '0;
            ex_writeAddr <= '0;
            ex_imm       <= '0;
            ex_ctrl      <= '0;
            stall_cnt    <= '0;
        end else if (flush || (!ex_hold && hazard_stall)) begin
            ex_valid     <= 1'b0;
            ex_readAddr1 <= '0;
            ex_readAddr2 <= '0;
            ex_operand1  <= '0;
            ex_operand2  <= '0;
            ex_writeAddr <= '0;
            ex_imm       <= '0;
            ex_ctrl      <= '0;
            if (!flush && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
        end else if (!ex_hold) begin
            ex_valid     <= id_valid;
            ex_readAddr1 <= id_readAddr1;
            ex_readAddr2 <= id_readAddr2;
            ex_operand1  <= operand1;
            ex_operand2  <= operand2;
            ex_writeAddr <= id_writeAddr;
            ex_imm       <= id_imm;
            ex_ctrl      <= id_valid ? id_ctrl : '0;
        end
    end

endmodule
